// File: rtl/conv_line_buffer.sv
// Two-row line buffer that turns a raster pixel stream into 3-pixel vertical columns.
// Optional macro LINEBUF_ZERO_PAD_EN: rows 0/1 also emit columns with missing rows zeroed.
module conv_line_buffer #(
  parameter int unsigned DATA_W     = 16,
  parameter int unsigned IMG_WIDTH  = 28,
  parameter int unsigned IMG_HEIGHT = 28
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic [DATA_W-1:0]   in_data_i,
  input  logic                in_valid_i,
  output logic                in_ready_o,
  output logic [3*DATA_W-1:0] out_data_o,
  output logic                out_valid_o,
  input  logic                out_ready_i,
  output logic                out_first_col_o,
  output logic                out_last_col_o,
  output logic                out_last_row_o
);

  localparam int unsigned CW = (IMG_WIDTH > 1) ? $clog2(IMG_WIDTH) : 1;
  localparam int unsigned RW = (IMG_HEIGHT > 1) ? $clog2(IMG_HEIGHT) : 1;
  localparam logic [CW-1:0] ColLast = CW'(IMG_WIDTH - 1);
  localparam logic [RW-1:0] RowLast = RW'(IMG_HEIGHT - 1);

  // lb_a holds row r-2, lb_b holds row r-1, indexed by column.
  logic [DATA_W-1:0] lb_a_q [IMG_WIDTH];
  logic [DATA_W-1:0] lb_b_q [IMG_WIDTH];

  logic [CW-1:0]       col_q, col_d;
  logic [RW-1:0]       row_q, row_d;
  logic [3*DATA_W-1:0] out_data_q, out_data_d;
  logic                out_valid_q, out_valid_d;
  logic                first_q, first_d;
  logic                last_col_q, last_col_d;
  logic                last_row_q, last_row_d;

  logic              in_xfer;
  logic              emit;
  logic [DATA_W-1:0] top_rd, mid_rd;
  logic [DATA_W-1:0] top_col, mid_col;

  assign in_ready_o = !out_valid_q || out_ready_i;
  assign in_xfer    = in_valid_i && in_ready_o;
  assign top_rd     = lb_a_q[col_q];
  assign mid_rd     = lb_b_q[col_q];

`ifdef LINEBUF_ZERO_PAD_EN
  // Masking hides stale rows left over from the previous frame.
  assign emit    = 1'b1;
  assign top_col = (row_q < RW'(2)) ? '0 : top_rd;
  assign mid_col = (row_q == '0) ? '0 : mid_rd;
`else
  assign emit    = (row_q >= RW'(2));
  assign top_col = top_rd;
  assign mid_col = mid_rd;
`endif

  // Contents are don't-care after reset, so no reset on the storage.
  always_ff @(posedge clk_i) begin
    if (in_xfer) begin
      lb_a_q[col_q] <= mid_rd;
      lb_b_q[col_q] <= in_data_i;
    end
  end

  always_comb begin
    col_d       = col_q;
    row_d       = row_q;
    out_data_d  = out_data_q;
    out_valid_d = out_valid_q;
    first_d     = first_q;
    last_col_d  = last_col_q;
    last_row_d  = last_row_q;

    if (out_valid_q && out_ready_i) begin
      out_valid_d = 1'b0;
    end

    if (in_xfer) begin
      if (col_q == ColLast) begin
        col_d = '0;
        row_d = (row_q == RowLast) ? '0 : row_q + RW'(1);
      end else begin
        col_d = col_q + CW'(1);
      end

      if (emit) begin
        out_data_d  = {in_data_i, mid_col, top_col};
        out_valid_d = 1'b1;
        first_d     = (col_q == '0);
        last_col_d  = (col_q == ColLast);
        last_row_d  = (row_q == RowLast);
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      col_q       <= '0;
      row_q       <= '0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      first_q     <= 1'b0;
      last_col_q  <= 1'b0;
      last_row_q  <= 1'b0;
    end else begin
      col_q       <= col_d;
      row_q       <= row_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
      first_q     <= first_d;
      last_col_q  <= last_col_d;
      last_row_q  <= last_row_d;
    end
  end

  assign out_data_o      = out_data_q;
  assign out_valid_o     = out_valid_q;
  assign out_first_col_o = first_q;
  assign out_last_col_o  = last_col_q;
  assign out_last_row_o  = last_row_q;

endmodule

// File: tb/tb_conv_line_buffer.sv
// Scoreboard bench for conv_line_buffer on a 4x4 image; honours LINEBUF_ZERO_PAD_EN.
module tb_conv_line_buffer;

  localparam int W  = 4;
  localparam int H  = 4;
  localparam int NP = W * H;
`ifdef LINEBUF_ZERO_PAD_EN
  localparam bit PAD = 1'b1;
  localparam int NOUT = H * W;
`else
  localparam bit PAD = 1'b0;
  localparam int NOUT = (H - 2) * W;
`endif

  logic        clk_i = 1'b0;
  logic        rst_ni = 1'b0;
  logic [15:0] in_data = '0;
  logic        in_valid = 1'b0;
  logic        in_ready_o;
  logic [47:0] out_data_o;
  logic        out_valid_o;
  logic        out_ready = 1'b1;
  logic        out_first_col_o, out_last_col_o, out_last_row_o;

  conv_line_buffer #(.DATA_W(16), .IMG_WIDTH(W), .IMG_HEIGHT(H)) dut (
    .clk_i          (clk_i),
    .rst_ni         (rst_ni),
    .in_data_i      (in_data),
    .in_valid_i     (in_valid),
    .in_ready_o     (in_ready_o),
    .out_data_o     (out_data_o),
    .out_valid_o    (out_valid_o),
    .out_ready_i    (out_ready),
    .out_first_col_o(out_first_col_o),
    .out_last_col_o (out_last_col_o),
    .out_last_row_o (out_last_row_o)
  );

  always #5 clk_i = ~clk_i;

  int n_vec = 0;
  int n_err = 0;
  int p = 0;               // pixel index within the frame
  logic [50:0] exp_q[$];   // {first, last_col, last_row, data}
  logic [50:0] got[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_vec++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, req);
    end
  endtask

  function automatic logic [50:0] model(input int pp);
    int r = pp / W;
    int c = pp % W;
    logic [15:0] cur = 16'(pp + 1);
    logic [15:0] mid = (r >= 1) ? 16'(pp + 1 - W) : 16'h0;
    logic [15:0] top = (r >= 2) ? 16'(pp + 1 - 2 * W) : 16'h0;
    return {(c == 0), (c == W - 1), (r == H - 1), cur, mid, top};
  endfunction

  // Monitor: pops on each output transfer, and checks stability while stalled.
  logic        stalled_prev = 1'b0;
  logic [50:0] held;
  always @(negedge clk_i) begin
    if (rst_ni && out_valid_o && out_ready) begin
      got.push_back({out_first_col_o, out_last_col_o, out_last_row_o, out_data_o});
      if (exp_q.size() == 0) begin
        check("unexpected_output", 64'(out_data_o), 64'hDEAD);
      end else begin
        check("column", 64'({out_first_col_o, out_last_col_o, out_last_row_o, out_data_o}),
              64'(exp_q.pop_front()));
      end
    end
    if (rst_ni && out_valid_o && !out_ready) begin
      check("stall_in_ready", 64'(in_ready_o), 64'h0);
      if (stalled_prev) begin
        check("stall_hold", 64'({out_first_col_o, out_last_col_o, out_last_row_o, out_data_o}),
              64'(held));
      end
      held = {out_first_col_o, out_last_col_o, out_last_row_o, out_data_o};
      stalled_prev = 1'b1;
    end else begin
      stalled_prev = 1'b0;
    end
  end

  // Drives one pixel; optional stall drops out_ready for stall_n cycles first.
  task automatic send(input int stall_n, output int waits);
    waits = 0;
    in_valid = 1'b1;
    in_data = 16'(p + 1);
    if (stall_n > 0) out_ready = 1'b0;
    forever begin
      @(negedge clk_i);
      if (stall_n > 0 && waits == 0) check("stall_value", 64'(out_data_o), 64'h000A_0006_0002);
      if (in_ready_o) break;
      @(posedge clk_i); #1;
      waits++;
      if (waits == stall_n) out_ready = 1'b1;
      if (waits > 50) begin
        $display("FAIL in_ready_timeout: got 0 expected 1");
        $fatal(1, "in_ready never returned");
      end
    end
    if (((p / W) >= 2) || PAD) exp_q.push_back(model(p));
    @(posedge clk_i); #1;
    in_valid = 1'b0;
    p = (p + 1) % NP;
  endtask

  task automatic drain(input int n_expected);
    repeat (3) @(posedge clk_i);
    #1;
    check("drain_queue_empty", 64'(exp_q.size()), 64'h0);
    check("output_count", 64'(got.size()), 64'(n_expected));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int wt;
    int r;
    // Reset state
    #2;
    check("rst_out_valid", 64'(out_valid_o), 64'h0);
    check("rst_out_data", 64'(out_data_o), 64'h0);
    check("rst_flags", 64'({out_first_col_o, out_last_col_o, out_last_row_o}), 64'h0);
    check("rst_in_ready", 64'(in_ready_o), 64'h1);
    @(negedge clk_i); #2;
    rst_ni = 1'b1;
    @(posedge clk_i); #1;

    // Basic column
    got.delete();
    for (int i = 0; i < NP; i++) send(0, wt);
    drain(NOUT);
    if (PAD) begin
      check("pad_first", 64'(got[0]), 64'({3'b100, 48'h0001_0000_0000}));
      check("pad_fifth", 64'(got[4]), 64'({3'b100, 48'h0005_0001_0000}));
      check("pad_last", 64'(got[15]), 64'({3'b011, 48'h0010_000C_0008}));
    end else begin
      check("basic_first", 64'(got[0]), 64'({3'b100, 48'h0009_0005_0001}));
      check("basic_last", 64'(got[7]), 64'({3'b011, 48'h0010_000C_0008}));
    end

    // Backpressure during row 2, held at column for pixel 10
    got.delete();
    for (int i = 0; i < NP; i++) send((i == 10) ? 3 : 0, wt);
    drain(NOUT);

    // Throughput over two back-to-back frames
    got.delete();
    for (int i = 0; i < 2 * NP; i++) begin
      send(0, wt);
      check("no_input_bubble", 64'(wt), 64'h0);
    end
    drain(2 * NOUT);
    check("frame2_first", 64'(got[NOUT]), 64'(got[0]));
    check("frame2_first_val", 64'(got[NOUT][47:0]),
          PAD ? 64'h0001_0000_0000 : 64'h0009_0005_0001);

    // Reset mid-row after pixel 6
    for (int i = 0; i < 6; i++) send(0, wt);
    @(negedge clk_i); #1;
    rst_ni = 1'b0;
    #1;
    check("midrst_out_valid", 64'(out_valid_o), 64'h0);
    check("midrst_out_data", 64'(out_data_o), 64'h0);
    check("midrst_flags", 64'({out_first_col_o, out_last_col_o, out_last_row_o}), 64'h0);
    check("midrst_in_ready", 64'(in_ready_o), 64'h1);
    check("midrst_queue", 64'(exp_q.size()), 64'h0);
    exp_q.delete();
    p = 0;
    @(negedge clk_i); #2;
    rst_ni = 1'b1;
    @(posedge clk_i); #1;
    got.delete();
    for (int i = 0; i < NP; i++) send(0, wt);
    drain(NOUT);
    check("after_rst_first", 64'(got[0][47:0]),
          PAD ? 64'h0001_0000_0000 : 64'h0009_0005_0001);

    // Sparse input: one idle cycle after each pixel
    got.delete();
    for (int i = 0; i < NP; i++) begin
      r = p / W;
      send(0, wt);
      @(negedge clk_i);
      check("sparse_pulse", 64'(out_valid_o), 64'((r >= 2) || PAD));
      @(posedge clk_i); #1;
      check("sparse_gap", 64'(out_valid_o), 64'h0);
    end
    drain(NOUT);
    if (!PAD) check("sparse_first", 64'(got[0][47:0]), 64'h0009_0005_0001);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/conv_line_buffer.md
Name: conv_line_buffer

Overview:
- Upstream feeder for the 3x3 bfloat16 convolution kernel.
- Accepts a raster-order pixel stream, one 16-bit bfloat16 pixel per transfer.
- Keeps the two previous image rows in line buffers.
- Emits one 48-bit vertical column per accepted pixel:
  - [15:0] = top row (r-2)
  - [31:16] = middle row (r-1)
  - [47:32] = current row (r)
- This matches the kernel's column slot order 0/1/2 (top to bottom).

Parameters:
- DATA_W, 16: pixel width (bfloat16).
- IMG_WIDTH, 28: pixels per row; must be ≥ 3.
- IMG_HEIGHT, 28: rows per frame; must be ≥ 3.

Ports:
- clk, input, 1: single clock, rising edge.
- reset, input, 1: asynchronous, active-low reset.
- in_data, input, DATA_W: incoming pixel.
- in_valid, input, 1: in_data is valid.
- in_ready, output, 1: block can accept a pixel this cycle.
- out_data, output, 3*DATA_W: column {cur, mid, top}.
- out_valid, output, 1: out_data is valid.
- out_ready, input, 1: consumer accepts out_data.
- out_first_col, output, 1: out_data is column 0 of its row.
- out_last_col, output, 1: out_data is column IMG_WIDTH-1.
- out_last_row, output, 1: out_data is from row IMG_HEIGHT-1.

Behaviour:
- Reset (reset=0, asynchronous):
  - All outputs = 0, except in_ready, which follows its equation below and therefore reads 1.
  - col_cnt = 0, row_cnt = 0, out_valid = 0.
  - Line-buffer contents are don't-care.
- Transfers:
  - Input transfer = in_valid & in_ready.
  - Output transfer = out_valid & out_ready.
  - in_ready = !out_valid | out_ready. This is a single output register with combinational pass-through of ready; there is no skid buffer.
- On each input transfer at col c, row r:
  - Read-before-write: top_q = lbA[c], mid_q = lbB[c].
  - Write: lbA[c] <= mid_q, lbB[c] <= in_data.
  - col_cnt increments. When it wraps to 0, row_cnt increments. When row_cnt wraps from IMG_HEIGHT-1 to 0, the frame ends and the next frame starts with no gap.
- Output load:
  - If r ≥ 2, the next edge loads out_data = {in_data, mid_q, top_q}.
  - The same edge sets out_valid=1 and the flags out_first_col=(c==0), out_last_col=(c==IMG_WIDTH-1), out_last_row=(r==IMG_HEIGHT-1).
  - Latency is 1 cycle from input transfer to out_valid.
- Rows 0 and 1: pixels are accepted and stored, but no output is produced. The output register is unchanged and out_valid is cleared if it is being transferred that cycle.
- No input transfer but output transfer occurs: out_valid goes to 0 at the next edge.
- Simultaneous input and output transfer: the output register is reloaded with the new column with no bubble. Throughput is 1 column per cycle.
- Stall (out_valid=1, out_ready=0): in_ready=0, and out_data plus all flags hold stable.
- Reset mid-frame: counters go to 0 and the next pixel is treated as row 0, col 0. A partial output column is discarded.
- Counts:
  - Columns per frame = (IMG_HEIGHT-2)*IMG_WIDTH.
  - out_last_row & out_last_col is asserted on exactly one column per frame.

Optional Feature:
- Macro: LINEBUF_ZERO_PAD_EN.
- Defined: rows 0 and 1 also produce output columns.
  - Row 0: top and mid forced to 0.
  - Row 1: top forced to 0.
  - Stale line-buffer data from the previous frame is never visible.
  - Columns per frame = IMG_HEIGHT*IMG_WIDTH.
- Undefined: first output is at row 2, as described in Behaviour.

Test Plan:
- Basic column: IMG_WIDTH=4, IMG_HEIGHT=4; stream pixels 16'h0001..16'h0010 with out_ready=1.
  - 1st output is 48'h0009_0005_0001 with out_first_col=1.
  - 8th output is 48'h0010_000C_0008 with out_last_col=1 and out_last_row=1.
  - Exactly 8 outputs total.
- Backpressure: during row 2, drop out_ready for 3 cycles.
  - in_ready=0 for those cycles.
  - out_data stays at its held value, e.g. 48'h000A_0006_0002.
  - No pixel is lost.
  - Output sequence is identical to the unstalled run.
- Throughput: in_valid=1 and out_ready=1 continuously over 2 back-to-back frames.
  - One output per cycle from row 2 onward.
  - Frame 2's first output is 48'h0009_0005_0001 (same data re-sent), with no gap cycle.
- Reset mid-row: assert reset=0 after pixel 16'h0006, then restream 16'h0001..16'h0010.
  - All outputs read 0 during reset.
  - After reset, the first output is again 48'h0009_0005_0001.
- Zero pad, with LINEBUF_ZERO_PAD_EN defined: same stimulus as Basic column.
  - 1st output is 48'h0001_0000_0000.
  - 5th output is 48'h0005_0001_0000.
  - 16 outputs total.
- Sparse input: in_valid toggles 1/0 every cycle.
  - out_valid pulses one cycle after each accepted row ≥ 2 pixel.
  - Column values match the Basic column test.
